// File: rtl/pixel_array_pkg.sv
// pixel_array_pkg
//   Shared definitions for the pixel array controller:
//   - parameter defaults for pixel count, data width, erase length and
//     exposure-time width
//   - the controller state enumeration
//   - a helper that sizes the shared phase counter
package pixel_array_pkg;

  localparam int DEF_N_PIX     = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ERASE_CYC = 5;
  localparam int DEF_EXP_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READOUT = 3'd4
  } state_t;

  // Width of the shared phase counter: wide enough for the exposure time,
  // the conversion ramp and the erase length.
  function automatic int cnt_width(input int data_w, input int exp_w, input int erase_cyc);
    int w;
    w = data_w;
    if (exp_w > w) w = exp_w;
    if ($clog2(erase_cyc + 1) > w) w = $clog2(erase_cyc + 1);
    return w;
  endfunction

endpackage

// File: rtl/pixel_array_ctrl_if.sv
// pixel_array_ctrl_if
//   Readout stream carrying one converted pixel per valid/ready handshake.
//   Signals:
//     pix_valid  controller -> sink   pixel sample available
//     pix_ready  sink -> controller   sink accepts the sample
//     pix_data   controller -> sink   captured pixel value (DATA_W)
//     pix_idx    controller -> sink   pixel index (clog2(N_PIX))
//   Modports: master (controller side), slave (sink side).
interface pixel_array_ctrl_if #(
  parameter int N_PIX  = 4,
  parameter int DATA_W = 8
);
  localparam int IDX_W = $clog2(N_PIX);

  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic [IDX_W-1:0]  pix_idx;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_idx,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_idx,
    output pix_ready
  );

endinterface

// File: rtl/gray_counter.sv
// gray_counter
//   Binary up-counter with a registered Gray-coded copy of its value.
//   Both outputs are registered, so gray always equals bin ^ (bin >> 1).
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset (clears both outputs)
//     en     advance the count by one
//     clr    synchronous clear to zero (has priority over en)
//     bin    binary count
//     gray   Gray code of bin
module gray_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] gray_reg;
  logic [WIDTH-1:0] bin_inc;

  assign bin_inc = bin_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg  <= '0;
      gray_reg <= '0;
    end else if (clr) begin
      bin_reg  <= '0;
      gray_reg <= '0;
    end else if (en) begin
      bin_reg  <= bin_inc;
      // Gray of the next value, so the registered pair stays consistent.
      gray_reg <= bin_inc ^ (bin_inc >> 1);
    end
  end

  assign bin  = bin_reg;
  assign gray = gray_reg;

endmodule

// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl
//   Frame sequencer for a small array of pixel sensors sharing one data bus.
//   Phases: IDLE -> ERASE -> EXPOSE -> CONVERT -> READOUT -> (ERASE | IDLE).
//   During CONVERT a Gray-coded ramp is driven on the shared bus; during
//   READOUT each pixel is selected in turn, its bus value captured after one
//   settle cycle and offered on the readout stream.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start               frame request (only honoured in IDLE)
//     cont                continuous mode, sampled on the final handshake
//     exp_time            exposure length in cycles, latched at frame start
//     erase/expose/convert pixel phase controls
//     read                one-hot pixel read select
//     data_oe, data_drv   bus drive enable and Gray ramp value
//     data_in             sampled bus value
//     pix                 readout stream (master side)
//     busy                controller not idle
//     frame_done          one-cycle pulse on the last pixel handshake
module pixel_array_ctrl
  import pixel_array_pkg::*;
#(
  parameter int N_PIX     = DEF_N_PIX,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ERASE_CYC = DEF_ERASE_CYC,
  parameter int EXP_W     = DEF_EXP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont,
  input  logic [EXP_W-1:0]    exp_time,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [N_PIX-1:0]    read,
  output logic                data_oe,
  output logic [DATA_W-1:0]   data_drv,
  input  logic [DATA_W-1:0]   data_in,
  pixel_array_ctrl_if.master  pix,
  output logic                busy,
  output logic                frame_done
);

  localparam int IDX_W = $clog2(N_PIX);
  localparam int CNT_W = cnt_width(DATA_W, EXP_W, ERASE_CYC);

  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_PIX - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [EXP_W-1:0]   exp_reg, exp_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               valid_reg, valid_next;
  logic [DATA_W-1:0]  data_reg, data_next;

  logic [DATA_W-1:0]  ramp_bin;
  logic [DATA_W-1:0]  ramp_gray;
  logic [CNT_W-1:0]   expose_load;
  logic               handshake;
  logic               last_pix;

  // Exposure of zero still gets one cycle; counter holds length-1.
  assign expose_load = (exp_reg == '0) ? '0 : (CNT_W'(exp_reg) - 1'b1);

  assign last_pix  = (idx_reg == LAST_IDX);
  assign handshake = (state_reg == ST_READOUT) && valid_reg && pix.pix_ready;

  // Ramp generator: held clear outside CONVERT so it restarts at 0 on entry.
  gray_counter #(
    .WIDTH (DATA_W)
  ) u_ramp (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_reg == ST_CONVERT),
    .clr   (state_reg != ST_CONVERT),
    .bin   (ramp_bin),
    .gray  (ramp_gray)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      exp_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      exp_reg   <= exp_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    exp_next   = exp_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    data_next  = data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          exp_next   = exp_time;
          cnt_next   = ERASE_LOAD;
          state_next = ST_ERASE;
        end
      end

      ST_ERASE: begin
        if (cnt_reg == '0) begin
          cnt_next   = expose_load;
          state_next = ST_EXPOSE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_EXPOSE: begin
        if (cnt_reg == '0) begin
          state_next = ST_CONVERT;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_CONVERT: begin
        // Last ramp step is when the binary count is all ones.
        if (ramp_bin == '1) begin
          idx_next   = '0;
          valid_next = 1'b0;
          state_next = ST_READOUT;
        end
      end

      ST_READOUT: begin
        if (!valid_reg) begin
          // Settle cycle: READ has been high for one cycle, capture the bus.
          data_next  = data_in;
          valid_next = 1'b1;
        end else if (pix.pix_ready) begin
          valid_next = 1'b0;
          if (last_pix) begin
            idx_next = '0;
            if (cont) begin
              exp_next   = exp_time;
              cnt_next   = ERASE_LOAD;
              state_next = ST_ERASE;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Phase outputs decode directly from the state register so they switch on
  // the same edge as the state. READ only asserts in READOUT and DATA_OE
  // only in CONVERT, so the two can never overlap on the bus.
  assign erase   = (state_reg == ST_ERASE);
  assign expose  = (state_reg == ST_EXPOSE);
  assign convert = (state_reg == ST_CONVERT);
  assign data_oe = (state_reg == ST_CONVERT);
  assign data_drv = data_oe ? ramp_gray : '0;
  assign busy    = (state_reg != ST_IDLE);

  generate
    for (genvar gi = 0; gi < N_PIX; gi++) begin : g_read
      assign read[gi] = (state_reg == ST_READOUT) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign frame_done = handshake && last_pix;

  assign pix.pix_valid = valid_reg;
  assign pix.pix_data  = data_reg;
  assign pix.pix_idx   = idx_reg;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb_pixel_array_ctrl
//   Drives frames through pixel_array_ctrl and checks every cycle against an
//   expected timeline built from the phase lengths (erase, max(exp,1),
//   2^DATA_W ramp steps) and a per-pixel handshake model. The bench also
//   plays the pixel array: it puts the selected pixel's value on data_in in
//   the settle cycle and garbage otherwise.
module tb_pixel_array_ctrl;
  import pixel_array_pkg::*;

  localparam int N_PIX     = DEF_N_PIX;
  localparam int DATA_W    = DEF_DATA_W;
  localparam int ERASE_CYC = DEF_ERASE_CYC;
  localparam int EXP_W     = DEF_EXP_W;
  localparam int IDX_W     = $clog2(N_PIX);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic [EXP_W-1:0]  exp_time = '0;
  logic              erase, expose, convert, data_oe, busy, frame_done;
  logic [N_PIX-1:0]  read;
  logic [DATA_W-1:0] data_drv;
  logic [DATA_W-1:0] data_in = '0;

  logic [DATA_W-1:0] pix_vals [N_PIX];

  int vectors     = 0;
  int miscompares = 0;

  pixel_array_ctrl_if #(.N_PIX(N_PIX), .DATA_W(DATA_W)) pix ();

  always #5 clk = ~clk;

  pixel_array_ctrl #(
    .N_PIX     (N_PIX),
    .DATA_W    (DATA_W),
    .ERASE_CYC (ERASE_CYC),
    .EXP_W     (EXP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .exp_time   (exp_time),
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .read       (read),
    .data_oe    (data_oe),
    .data_drv   (data_drv),
    .data_in    (data_in),
    .pix        (pix),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_phase(input string tag, input bit er, input bit ex, input bit cv);
    check({tag, ".erase"},   32'(erase),      32'(er));
    check({tag, ".expose"},  32'(expose),     32'(ex));
    check({tag, ".convert"}, 32'(convert),    32'(cv));
    check({tag, ".data_oe"}, 32'(data_oe),    32'(cv));
    check({tag, ".read"},    32'(read),       32'd0);
    check({tag, ".valid"},   32'(pix.pix_valid), 32'd0);
    check({tag, ".busy"},    32'(busy),       32'd1);
    check({tag, ".fdone"},   32'(frame_done), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".erase"},    32'(erase),         32'd0);
    check({tag, ".expose"},   32'(expose),        32'd0);
    check({tag, ".convert"},  32'(convert),       32'd0);
    check({tag, ".read"},     32'(read),          32'd0);
    check({tag, ".data_oe"},  32'(data_oe),       32'd0);
    check({tag, ".data_drv"}, 32'(data_drv),      32'd0);
    check({tag, ".valid"},    32'(pix.pix_valid), 32'd0);
    check({tag, ".fdone"},    32'(frame_done),    32'd0);
    check({tag, ".busy"},     32'(busy),          32'd0);
  endtask

  // Runs one frame. If from_idle, pulses start at the current negedge;
  // otherwise the current negedge is expected to be the first ERASE cycle.
  // Returns at the negedge right after the final handshake.
  task automatic do_frame(input int e, input bit from_idle, input bit cont_val,
                          input int next_e, input bit poke_start,
                          input int stall_pix, input int stall_len);
    int ex_len;
    int stall;
    ex_len = (e == 0) ? 1 : e;
    if (from_idle) begin
      exp_time = EXP_W'(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Exposure must come from the latched value, not the live input.
      exp_time = EXP_W'($urandom);
    end
    for (int i = 0; i < ERASE_CYC; i++) begin
      check_phase("erase", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < ex_len; i++) begin
      check_phase("expose", 1'b0, 1'b1, 1'b0);
      if (poke_start) start = (i == 0);
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < (1 << DATA_W); k++) begin
      check_phase("convert", 1'b0, 1'b0, 1'b1);
      check("data_drv", 32'(data_drv), 32'(k ^ (k >> 1)));
      @(negedge clk);
    end
    for (int p = 0; p < N_PIX; p++) begin
      stall = (p == stall_pix) ? stall_len : int'($urandom_range(0, 3));
      check("settle.read",  32'(read),          32'(1 << p));
      check("settle.valid", 32'(pix.pix_valid), 32'd0);
      check("settle.oe",    32'(data_oe),       32'd0);
      check("settle.fdone", 32'(frame_done),    32'd0);
      data_in = pix_vals[p];
      pix.pix_ready = 1'($urandom_range(0, 1));
      for (int c = 0; c <= stall; c++) begin
        @(negedge clk);
        data_in = DATA_W'($urandom);
        pix.pix_ready = (c == stall);
        if (c == stall && p == N_PIX - 1) begin
          cont = cont_val;
          exp_time = EXP_W'(next_e);
        end
        #1;
        check("hold.read",  32'(read),          32'(1 << p));
        check("hold.valid", 32'(pix.pix_valid), 32'd1);
        check("hold.data",  32'(pix.pix_data),  32'(pix_vals[p]));
        check("hold.idx",   32'(pix.pix_idx),   32'(p));
        check("hold.oe",    32'(data_oe),       32'd0);
        check("hold.fdone", 32'(frame_done),    32'((c == stall) && (p == N_PIX - 1)));
      end
      $display("pixel %0d data=0x%0h stall=%0d", p, pix_vals[p], stall);
      @(negedge clk);
      pix.pix_ready = 1'b0;
    end
    cont = 1'b0;
  endtask

  task automatic expect_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("idle.busy",  32'(busy),  32'd0);
      check("idle.erase", 32'(erase), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic randomize_pixels();
    for (int p = 0; p < N_PIX; p++) pix_vals[p] = DATA_W'($urandom);
  endtask

  initial begin
    int e;
    int e2;
    pix.pix_ready = 1'b0;
    randomize_pixels();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Nominal frame with the directed pixel values and a long stall on pixel 2.
    pix_vals[0] = 8'h5A;
    pix_vals[1] = 8'h3C;
    pix_vals[2] = 8'hFF;
    pix_vals[3] = 8'h00;
    do_frame(10, 1'b1, 1'b0, 0, 1'b0, 2, 7);
    $display("frame done: exp=10 directed");
    expect_idle(2);

    // Zero exposure, with a START poke during EXPOSE that must be ignored.
    randomize_pixels();
    do_frame(0, 1'b1, 1'b0, 0, 1'b1, -1, 0);
    $display("frame done: exp=0 with start poke");
    expect_idle(4);

    // Continuous mode: second frame starts right after FRAME_DONE.
    randomize_pixels();
    e  = int'($urandom_range(0, 12));
    e2 = int'($urandom_range(0, 12));
    do_frame(e, 1'b1, 1'b1, e2, 1'b0, -1, 0);
    $display("frame done: exp=%0d continuous", e);
    randomize_pixels();
    do_frame(e2, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    $display("frame done: exp=%0d end of continuous run", e2);
    expect_idle(2);

    // Asynchronous reset in the middle of CONVERT.
    exp_time = EXP_W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (ERASE_CYC + 3 + 40) @(negedge clk);
    check("pre_reset.convert", 32'(convert), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset applied during convert");
    randomize_pixels();
    e = int'($urandom_range(0, 12));
    do_frame(e, 1'b1, 1'b0, 0, 1'b0, -1, 0);
    $display("frame done: exp=%0d after reset", e);
    expect_idle(2);

    // A few fully random frames.
    for (int f = 0; f < 3; f++) begin
      randomize_pixels();
      e = int'($urandom_range(0, 20));
      do_frame(e, 1'b1, 1'b0, 0, 1'b0, int'($urandom_range(0, N_PIX - 1)), int'($urandom_range(0, 6)));
      $display("frame done: exp=%0d random", e);
      expect_idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
